// File: rtl/uart_io_pkg.sv
// rtl/uart_io_pkg.sv - shared register map, STATUS bit positions and drain FSM states
package uart_io_pkg;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_RXDATA = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_TERM   = 3'd4;
  localparam logic [13:0] REG_COUNT = 14'd5;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_NONEMPTY = 2;
  localparam int ST_RX_FULL     = 3;
  localparam int ST_TX_OVF      = 4;
  localparam int ST_RX_OVF      = 5;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_ISSUE = 2'd1,
    DRAIN_GAP   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/uart_io_fifo.sv
// rtl/uart_io_fifo.sv - synchronous byte FIFO; a push into a full FIFO is taken when a pop happens in the same cycle
module uart_io_fifo #(
  parameter int AW = 3,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_io_regs.sv
// rtl/uart_io_regs.sv - CPU-side UART register block: TX/RX FIFOs, sticky overflows, CTRL/TERM
module uart_io_regs
  import uart_io_pkg::*;
#(
  parameter logic [13:0] BASE_ADR     = 14'h0100,
  parameter int          FIFO_AW      = 3,
  parameter logic [15:0] TERM_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_we,
  input  logic [15:2] io_wadr,
  input  logic [31:0] io_wdata,
  input  logic        io_radr_en,
  input  logic [15:2] io_radr,
  output logic [31:0] io_rdata,
  output logic [7:0]  uart_io_char,
  output logic        uart_io_we,
  input  logic        uart_io_full,
  input  logic [7:0]  rout,
  input  logic        rout_en,
  output logic        rx_disable_echoback,
  output logic [15:0] uart_term,
  output logic        rx_irq
);

  logic [13:0] w_off, r_off;
  logic        w_hit, r_hit;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;
  logic [FIFO_AW:0] tx_cnt, rx_cnt;
  logic        tx_ovf, rx_ovf;
  logic [1:0]  ctrl;
  logic        sts_wr;
  logic [31:0] status_word;
  logic [31:0] rdata_next;
  drain_state_t drain_state;

  // Subtraction wraps below BASE_ADR, so one unsigned compare bounds both ends.
  assign w_off = io_wadr - BASE_ADR;
  assign r_off = io_radr - BASE_ADR;
  assign w_hit = io_we & (w_off < REG_COUNT);
  assign r_hit = io_radr_en & (r_off < REG_COUNT);

  assign tx_push = w_hit & (w_off[2:0] == REG_TXDATA);
  assign sts_wr  = w_hit & (w_off[2:0] == REG_STATUS);
  assign rx_push = rout_en & ctrl[0];
  assign rx_pop  = r_hit & (r_off[2:0] == REG_RXDATA) & ~rx_empty;
  assign tx_pop  = (drain_state != DRAIN_ISSUE) & ~tx_empty & ~uart_io_full;

  uart_io_fifo #(.AW(FIFO_AW), .W(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .din   (io_wdata[7:0]),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  uart_io_fifo #(.AW(FIFO_AW), .W(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .din   (rout),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  assign rx_disable_echoback = ctrl[0];
  assign rx_irq = ctrl[1] & ~rx_empty;

  always_comb begin
    status_word = '0;
    status_word[ST_TX_FULL]     = tx_full;
    status_word[ST_TX_EMPTY]    = tx_empty;
    status_word[ST_RX_NONEMPTY] = ~rx_empty;
    status_word[ST_RX_FULL]     = rx_full;
    status_word[ST_TX_OVF]      = tx_ovf;
    status_word[ST_RX_OVF]      = rx_ovf;
    status_word[10:8]           = rx_cnt[2:0];
  end

  always_comb begin
    rdata_next = '0;
    if (r_hit) begin
      case (r_off[2:0])
        REG_RXDATA: rdata_next = {~rx_empty, 23'b0, rx_empty ? 8'h00 : rx_head};
        REG_STATUS: rdata_next = status_word;
        REG_CTRL:   rdata_next = {30'b0, ctrl};
        REG_TERM:   rdata_next = {16'b0, uart_term};
        default:    rdata_next = '0;
      endcase
    end
  end

  // Overflow only when no pop frees a slot this cycle; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
      ctrl      <= 2'b00;
      uart_term <= TERM_DEFAULT;
      io_rdata  <= '0;
    end else begin
      tx_ovf <= (tx_push & tx_full & ~tx_pop) |
                (tx_ovf & ~(sts_wr & io_wdata[ST_TX_OVF]));
      rx_ovf <= (rx_push & rx_full & ~rx_pop) |
                (rx_ovf & ~(sts_wr & io_wdata[ST_RX_OVF]));
      if (w_hit && w_off[2:0] == REG_CTRL) ctrl <= io_wdata[1:0];
      if (w_hit && w_off[2:0] == REG_TERM) uart_term <= io_wdata[15:0];
      io_rdata <= rdata_next;
    end
  end

  // GAP re-checks uart_io_full after it has seen the previous strobe, allowing one char per 2 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_state  <= DRAIN_IDLE;
      uart_io_we   <= 1'b0;
      uart_io_char <= 8'h00;
    end else begin
      case (drain_state)
        DRAIN_IDLE, DRAIN_GAP: begin
          if (tx_pop) begin
            drain_state  <= DRAIN_ISSUE;
            uart_io_we   <= 1'b1;
            uart_io_char <= tx_head;
          end else begin
            drain_state <= DRAIN_IDLE;
            uart_io_we  <= 1'b0;
          end
        end
        DRAIN_ISSUE: begin
          drain_state <= DRAIN_GAP;
          uart_io_we  <= 1'b0;
        end
        default: begin
          drain_state <= DRAIN_IDLE;
          uart_io_we  <= 1'b0;
        end
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{io_wdata[31:16], w_off[13:3], r_off[13:3], tx_cnt, rx_cnt[FIFO_AW:3]};

endmodule

// File: tb/tb_uart_io_regs.sv
// tb/tb_uart_io_regs.sv - scoreboard bench for uart_io_regs
module tb_uart_io_regs;

  localparam logic [13:0] BASE = 14'h0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_we;
  logic [15:2] io_wadr;
  logic [31:0] io_wdata;
  logic        io_radr_en;
  logic [15:2] io_radr;
  logic [31:0] io_rdata;
  logic [7:0]  uart_io_char;
  logic        uart_io_we;
  logic        uart_io_full;
  logic [7:0]  rout;
  logic        rout_en;
  logic        rx_disable_echoback;
  logic [15:0] uart_term;
  logic        rx_irq;

  int pass_cnt = 0;
  int check_cnt = 0;
  int cyc = 0;
  logic rd_flag = 1'b0;
  logic [7:0]  tx_q [$];
  logic [31:0] rd_q [$];
  int pulse_cyc [$];

  always #5 clk = ~clk;

  uart_io_regs dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .io_we               (io_we),
    .io_wadr             (io_wadr),
    .io_wdata            (io_wdata),
    .io_radr_en          (io_radr_en),
    .io_radr             (io_radr),
    .io_rdata            (io_rdata),
    .uart_io_char        (uart_io_char),
    .uart_io_we          (uart_io_we),
    .uart_io_full        (uart_io_full),
    .rout                (rout),
    .rout_en             (rout_en),
    .rx_disable_echoback (rx_disable_echoback),
    .uart_term           (uart_term),
    .rx_irq              (rx_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_flag <= io_radr_en;
  end

  always @(negedge clk) begin
    if (uart_io_we) begin
      pulse_cyc.push_back(cyc);
      if (tx_q.size() == 0) begin
        check_cnt++;
        $display("FAIL tx_unexpected: got char %02h expected no strobe", uart_io_char);
      end else begin
        check("tx_char", {24'b0, uart_io_char}, {24'b0, tx_q.pop_front()});
      end
    end
    if (rd_flag) begin
      if (rd_q.size() == 0) begin
        check_cnt++;
        $display("FAIL rd_unexpected: got %08h expected no read", io_rdata);
      end else begin
        check("rdata", io_rdata, rd_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    io_we = 1'b1; io_wadr = BASE + 14'(off); io_wdata = d;
    @(posedge clk); #1;
    io_we = 1'b0;
  endtask

  task automatic tx_wr(input logic [7:0] c, input bit expect_out);
    if (expect_out) tx_q.push_back(c);
    wr(3'd0, {24'b0, c});
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp);
    rd_q.push_back(exp);
    io_radr_en = 1'b1; io_radr = BASE + 14'(off);
    @(posedge clk); #1;
    io_radr_en = 1'b0;
  endtask

  task automatic rx_char(input logic [7:0] c);
    rout = c; rout_en = 1'b1;
    @(posedge clk); #1;
    rout_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || rd_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    if (tx_q.size() != 0 || rd_q.size() != 0) begin
      check_cnt++;
      $display("FAIL drain_timeout: got %0d tx / %0d rd pending expected 0", tx_q.size(), rd_q.size());
      tx_q.delete();
      rd_q.delete();
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; io_we = 1'b0; io_wadr = '0; io_wdata = '0;
    io_radr_en = 1'b0; io_radr = '0; uart_io_full = 1'b0; rout = '0; rout_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_rdata", io_rdata, 32'h0);
    check("rst_term_port", {16'b0, uart_term}, 32'd434);
    check("rst_irq", {31'b0, rx_irq}, 32'h0);
    rd(3'd4, 32'h0000_01B2);
    rd(3'd2, 32'h0000_0002);
    repeat (4) @(posedge clk); #1;
    check("rst_no_we", pulse_cyc.size(), 0);

    tx_wr(8'h41, 1'b1);
    tx_wr(8'h42, 1'b1);
    tx_wr(8'h43, 1'b1);
    wait_drain(50);
    check("tx_pulses", pulse_cyc.size(), 3);
    if (pulse_cyc.size() >= 3) begin
      check("tx_gap01", pulse_cyc[1] - pulse_cyc[0], 2);
      check("tx_gap12", pulse_cyc[2] - pulse_cyc[1], 2);
    end

    uart_io_full = 1'b1;
    tx_wr(8'h61, 1'b1);
    tx_wr(8'h62, 1'b1);
    n = pulse_cyc.size();
    repeat (10) @(posedge clk); #1;
    check("hold_no_we", pulse_cyc.size(), n);
    uart_io_full = 1'b0;
    wait_drain(50);
    check("hold_released", pulse_cyc.size(), n + 2);

    uart_io_full = 1'b1;
    for (int i = 0; i < 9; i++) tx_wr(8'h70 + 8'(i), i < 8);
    rd(3'd2, 32'h0000_0011);
    wr(3'd2, 32'h0000_0010);
    rd(3'd2, 32'h0000_0001);
    uart_io_full = 1'b0;
    wait_drain(100);

    rd_q.push_back(32'h0000_0002);
    io_we = 1'b1; io_wadr = BASE + 14'd4; io_wdata = 32'h0000_1234;
    io_radr_en = 1'b1; io_radr = BASE + 14'd2;
    @(posedge clk); #1;
    io_we = 1'b0; io_radr_en = 1'b0;
    rd(3'd4, 32'h0000_1234);
    check("term_port", {16'b0, uart_term}, 32'h0000_1234);

    wr(3'd3, 32'h3);
    check("echo_port", {31'b0, rx_disable_echoback}, 32'h1);
    rx_char(8'h5A);
    check("irq_set", {31'b0, rx_irq}, 32'h1);
    rd(3'd1, 32'h8000_005A);
    check("irq_clr", {31'b0, rx_irq}, 32'h0);
    rd(3'd1, 32'h0000_0000);

    wr(3'd3, 32'h0);
    for (int i = 0; i < 3; i++) rx_char(8'hC0 + 8'(i));
    rd(3'd2, 32'h0000_0002);

    wr(3'd3, 32'h1);
    for (int i = 0; i < 9; i++) rx_char(8'h10 + 8'(i));
    rd(3'd2, 32'h0000_002E);
    for (int i = 0; i < 8; i++) rd(3'd1, 32'h8000_0010 + 32'(i));
    rd(3'd2, 32'h0000_0022);
    wr(3'd2, 32'h0000_0020);
    rd(3'd2, 32'h0000_0002);

    for (int i = 0; i < 8; i++) rx_char(8'h20 + 8'(i));
    rd_q.push_back(32'h8000_0020);
    rout = 8'h28; rout_en = 1'b1;
    io_radr_en = 1'b1; io_radr = BASE + 14'd1;
    @(posedge clk); #1;
    rout_en = 1'b0; io_radr_en = 1'b0;
    rd(3'd2, 32'h0000_000E);
    for (int i = 0; i < 8; i++) rd(3'd1, 32'h8000_0021 + 32'(i));
    rd(3'd2, 32'h0000_0002);

    wait_drain(50);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
